// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle LC-3b ALU with iterative one-bit-per-cycle shifter
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   in_valid/ready   request handshake; op, a, b captured on accept
//   out_valid/ready  result handshake; result and n/z/p held while out_valid
//   busy             high whenever the FSM is not idle
module alu_mc #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             n,
    output logic             z,
    output logic             p,
    output logic             busy
);

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_XOR   = 3'b010;
    localparam logic [2:0] OP_LSHF  = 3'b011;
    localparam logic [2:0] OP_RSHFL = 3'b100;
    localparam logic [2:0] OP_RSHFA = 3'b101;
    localparam logic [2:0] OP_SUB   = 3'b110;
    localparam logic [2:0] OP_PASSB = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [SHW-1:0]   r_cnt;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_result;
    logic             r_n;
    logic             r_z;
    logic             r_p;

    logic             w_accept;
    logic [SHW-1:0]   w_shamt;
    logic             w_is_shift;
    logic             w_start_shift;
    logic [WIDTH-1:0] w_alu;
    logic [WIDTH-1:0] w_acc_shifted;
    logic             w_shift_last;
    logic             w_load;
    logic [WIDTH-1:0] w_load_val;

    // in_ready depends only on state and out_ready, never on in_valid.
    assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_shamt   = b[SHW-1:0];
    assign w_is_shift = (op == OP_LSHF) || (op == OP_RSHFL) || (op == OP_RSHFA);
    assign w_start_shift = w_accept && w_is_shift && (w_shamt != '0);
    assign w_shift_last  = (r_state == S_SHIFT) && (r_cnt == SHW'(1));

    // Single-cycle datapath. Shift ops only reach here with shamt=0, so they pass A.
    always_comb begin
        w_alu = '0;
        case (op)
            OP_AND:   w_alu = a & b;
            OP_ADD:   w_alu = a + b;
            OP_XOR:   w_alu = a ^ b;
            OP_SUB:   w_alu = a - b;
            OP_PASSB: w_alu = b;
            default:  w_alu = a;
        endcase
    end

    // One-bit step of the iterative shifter, direction/fill from the captured op.
    always_comb begin
        w_acc_shifted = r_acc;
        case (r_op)
            OP_LSHF:  w_acc_shifted = {r_acc[WIDTH-2:0], 1'b0};
            OP_RSHFL: w_acc_shifted = {1'b0, r_acc[WIDTH-1:1]};
            OP_RSHFA: w_acc_shifted = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
            default:  w_acc_shifted = r_acc;
        endcase
    end

    // Result/flags load either on a single-cycle accept or on the last shift step.
    assign w_load     = (w_accept && !w_start_shift) || w_shift_last;
    assign w_load_val = w_shift_last ? w_acc_shifted : w_alu;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_op    <= '0;
        end else begin
            if (w_accept) begin
                // Accept is only possible from IDLE or from DONE with out_ready.
                if (w_start_shift) begin
                    r_acc   <= a;
                    r_cnt   <= w_shamt;
                    r_op    <= op;
                    r_state <= S_SHIFT;
                end else begin
                    r_state <= S_DONE;
                end
            end else begin
                case (r_state)
                    S_SHIFT: begin
                        r_acc <= w_acc_shifted;
                        r_cnt <= r_cnt - SHW'(1);
                        if (w_shift_last) begin
                            r_state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        if (out_ready) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_n      <= 1'b0;
            r_z      <= 1'b1;
            r_p      <= 1'b0;
        end else if (w_load) begin
            r_result <= w_load_val;
            r_n      <= w_load_val[WIDTH-1];
            r_z      <= (w_load_val == '0);
            r_p      <= !w_load_val[WIDTH-1] && (w_load_val != '0);
        end
    end

    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign result    = r_result;
    assign n         = r_n;
    assign z         = r_z;
    assign p         = r_p;

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - self-checking bench for alu_mc (16-bit and 32-bit instances)
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  op;
    logic [15:0] a, b, result;
    logic        n, z, p, busy;

    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [2:0]  c_op;
    logic [31:0] c_a, c_b, c_result;
    logic        c_n, c_z, c_p, c_busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(16), .SHW(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .n(n), .z(z), .p(p), .busy(busy)
    );

    alu_mc #(.WIDTH(32), .SHW(5)) dut32 (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .op(c_op),
        .a(c_a), .b(c_b), .out_valid(c_out_valid), .out_ready(c_out_ready), .result(c_result),
        .n(c_n), .z(c_z), .p(c_p), .busy(c_busy)
    );

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [2:0]  nzp;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: spec arithmetic on whole words, shifts via SV shift operators.
    function automatic logic [15:0] ref16(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
        logic signed [15:0] sx;
        int sh;
        sx = x;
        sh = int'(y[3:0]);
        case (o)
            3'd0: return x & y;
            3'd1: return x + y;
            3'd2: return x ^ y;
            3'd3: return x << sh;
            3'd4: return x >> sh;
            3'd5: return sx >>> sh;
            3'd6: return x - y;
            default: return y;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [15:0] y);
        if ((o == 3'd3 || o == 3'd4 || o == 3'd5) && y[3:0] != 4'd0) return int'(y[3:0]) + 1;
        return 1;
    endfunction

    function automatic logic [2:0] ref_nzp(input logic [15:0] r);
        if (r[15]) return 3'b100;
        if (r == 16'd0) return 3'b010;
        return 3'b001;
    endfunction

    // Issue one op from IDLE, measure latency, hold the result for 'hold' cycles.
    task automatic do_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] exp_res, input logic [2:0] exp_nzp,
                         input int exp_lat, input int hold, input string tag);
        int lat;
        logic [15:0] held;
        out_ready = 1'b0;
        op = o; a = x; b = y; in_valid = 1'b1;
        #1;
        chk({tag, "_in_ready_idle"}, in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ~x; b = ~y; op = ~o;
        lat = 1;
        while (!out_valid && lat < 64) begin
            chk({tag, "_in_ready_shift"}, in_ready, 1'b0);
            chk({tag, "_busy_shift"}, busy, 1'b1);
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_nzp"}, {n, z, p}, exp_nzp);
        held = result;
        repeat (hold) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, out_valid, 1'b1);
            chk({tag, "_hold_result"}, result, held);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_drained"}, out_valid, 1'b0);
    endtask

    task automatic do_op32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] exp_res, input logic [2:0] exp_nzp,
                           input int exp_lat, input string tag);
        int lat;
        c_out_ready = 1'b1;
        c_op = o; c_a = x; c_b = y; c_in_valid = 1'b1;
        @(posedge clk); #1;
        c_in_valid = 1'b0;
        lat = 1;
        while (!c_out_valid && lat < 80) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_result"}, c_result, exp_res);
        chk({tag, "_nzp"}, {c_n, c_z, c_p}, exp_nzp);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[11];
        logic stale;
        vecs[0]  = '{3'd1, 16'h7FFF, 16'h0001, 16'h8000, 3'b100, 1};
        vecs[1]  = '{3'd5, 16'h8000, 16'h000F, 16'hFFFF, 3'b100, 16};
        vecs[2]  = '{3'd4, 16'h8000, 16'h000F, 16'h0001, 3'b001, 16};
        vecs[3]  = '{3'd3, 16'h1234, 16'hFFF0, 16'h1234, 3'b001, 1};
        vecs[4]  = '{3'd0, 16'hF0F0, 16'hFF00, 16'hF000, 3'b100, 1};
        vecs[5]  = '{3'd2, 16'hAAAA, 16'hAAAA, 16'h0000, 3'b010, 1};
        vecs[6]  = '{3'd6, 16'h0003, 16'h0005, 16'hFFFE, 3'b100, 1};
        vecs[7]  = '{3'd7, 16'hFFFF, 16'h0042, 16'h0042, 3'b001, 1};
        vecs[8]  = '{3'd3, 16'h0001, 16'h0004, 16'h0010, 3'b001, 5};
        vecs[9]  = '{3'd1, 16'hFFFF, 16'h0001, 16'h0000, 3'b010, 1};
        vecs[10] = '{3'd5, 16'h4000, 16'h0003, 16'h0800, 3'b001, 4};

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
        c_in_valid = 1'b0; c_out_ready = 1'b0; c_op = '0; c_a = '0; c_b = '0;
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_result", result, 16'h0000);
        chk("rst_nzp", {n, z, p}, 3'b010);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i])
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].nzp, vecs[i].lat, 0, $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  ro;
            logic [15:0] ra, rb, rr;
            ro = 3'($urandom_range(0, 7));
            ra = 16'($urandom);
            rb = 16'($urandom);
            rr = ref16(ro, ra, rb);
            do_op(ro, ra, rb, rr, ref_nzp(rr), ref_lat(ro, rb), int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
        end

        // Held result under backpressure, then back-to-back accept from DONE.
        out_ready = 1'b0;
        op = 3'd6; a = 16'd5; b = 16'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        op = 3'd1; a = 16'd1; b = 16'd1;
        repeat (5) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_result", result, 16'h0000);
            chk("hold_z", {n, z, p}, 3'b010);
            chk("hold_in_ready", in_ready, 1'b0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        op = 3'd2; a = 16'hFF00; b = 16'h0FF0;
        #1;
        chk("b2b_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        op = 3'd1; a = 16'd10; b = 16'd20;
        chk("b2b_valid", out_valid, 1'b1);
        chk("b2b_result", result, 16'hF0F0);
        chk("b2b_nzp", {n, z, p}, 3'b100);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b2_valid", out_valid, 1'b1);
        chk("b2b2_result", result, 16'd30);
        @(posedge clk); #1;
        chk("b2b_idle", out_valid, 1'b0);
        out_ready = 1'b0;

        // Asynchronous reset on the third SHIFT cycle discards the op.
        do_op(3'd1, 16'd1, 16'd1, 16'd2, 3'b001, 1, 0, "pre_rst");
        op = 3'd3; a = 16'h00FF; b = 16'd8; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("mid_busy", busy, 1'b1);
        chk("mid_in_ready", in_ready, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_result", result, 16'h0000);
        chk("arst_nzp", {n, z, p}, 3'b010);
        chk("arst_busy", busy, 1'b0);
        @(negedge clk) rst = 1'b0;
        stale = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) stale = 1'b1;
        end
        chk("no_stale", stale, 1'b0);
        out_ready = 1'b0;

        do_op32(3'd4, 32'h80000000, 32'd31, 32'h00000001, 3'b001, 32, "w32_rshfl");
        do_op32(3'd1, 32'hFFFFFFFF, 32'd1, 32'h00000000, 3'b010, 1, "w32_add");
        do_op32(3'd5, 32'h80000000, 32'd4, 32'hF8000000, 3'b100, 5, "w32_rshfa");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
